// File: rtl/tpu_pkg.sv
// Shared sizing for the operand path between the loader and the MMU input edge.
// Lane count, operand width and FIFO depth defaults, plus derived slice and count widths.
package tpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FIFO_WIDTH = 4;
  localparam int FIFO_DEPTH = 4;

  // One lane's bit-slice of a loader row, and the full row width.
  localparam int LANE_SLICE_W = DATA_WIDTH;
  localparam int ROW_WIDTH    = FIFO_WIDTH * LANE_SLICE_W;

  // Occupancy needs one more bit than the pointer so that "full" (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_lane.sv
// Single-lane synchronous FIFO: registered head output one cycle after pop; dout is zero when no pop fires.
// The caller must not push when full; a pop on an empty lane is ignored, and a same-cycle push is not visible to it.
module fifo_lane
  import tpu_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          pop_fire;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign pop_fire   = pop && !empty;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = '0;
    dout_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_fire) begin
        dout_d       = mem_q[rd_ptr_q];
        dout_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
      end
      // Pointers wrap on their own since DEPTH is a power of two; occupancy lives only in count.
      case ({push, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

endmodule

// File: rtl/skew_fifo_bank.sv
// Per-lane FIFO bank feeding the MMU diagonally: full rows in, independent per-lane pops, 1-cycle pop-to-data.
// wr_ready drops while any lane is full and recovers only the cycle after a pop frees space.
module skew_fifo_bank
  import tpu_pkg::*;
#(
  parameter int fifo_width = FIFO_WIDTH,
  parameter int data_width = DATA_WIDTH,
  parameter int depth      = FIFO_DEPTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      wr_valid,
  output logic                                      wr_ready,
  input  logic [fifo_width*data_width-1:0]          wr_data,
  input  logic [fifo_width-1:0]                     fifo_en,
  output logic [fifo_width*data_width-1:0]          rd_data,
  output logic [fifo_width-1:0]                     rd_valid,
  output logic [fifo_width-1:0]                     lane_empty,
  output logic [fifo_width*($clog2(depth)+1)-1:0]   lane_count,
  output logic                                      underflow
);

  localparam int CW = $clog2(depth) + 1;

  logic [fifo_width-1:0] lane_full;
  logic                  push;
  logic                  underflow_q, underflow_d;

  assign wr_ready  = ~|lane_full;
  assign push      = wr_valid && wr_ready;
  assign underflow = underflow_q;

  for (genvar i = 0; i < fifo_width; i++) begin : g_lane
    fifo_lane #(
      .DW    (data_width),
      .DEPTH (depth)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (push),
      .din        (wr_data[i*data_width +: data_width]),
      .pop        (fifo_en[i]),
      .dout       (rd_data[i*data_width +: data_width]),
      .dout_valid (rd_valid[i]),
      .empty      (lane_empty[i]),
      .full       (lane_full[i]),
      .count      (lane_count[i*CW +: CW])
    );
  end

  always_comb begin
    underflow_d = underflow_q | (|(fifo_en & lane_empty));
    if (flush) underflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= underflow_d;
  end

endmodule

// File: tb/tb_skew_fifo_bank.sv
// Randomized and directed bench for skew_fifo_bank: a queue-per-lane reference model feeds a scoreboard
// that a separate monitor drains whenever the bank presents lane outputs.
module tb_skew_fifo_bank;

  localparam int L  = 4;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [L*DW-1:0]   wr_data = '0;
  logic [L-1:0]      fifo_en = '0;
  logic [L*DW-1:0]   rd_data;
  logic [L-1:0]      rd_valid;
  logic [L-1:0]      lane_empty;
  logic [L*CW-1:0]   lane_count;
  logic              underflow;

  skew_fifo_bank #(.fifo_width(L), .data_width(DW), .depth(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .fifo_en    (fifo_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .lane_empty (lane_empty),
    .lane_count (lane_count),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: what each lane holds, plus the sticky underflow flag.
  logic [DW-1:0] mq [L][$];
  logic          m_uf = 1'b0;
  // Scoreboard: operands the bank must present on the edge following the pop.
  logic [DW-1:0] sb [L][$];

  int  n_pass = 0;
  int  n_total = 0;
  bit  mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [L*CW-1:0] model_counts();
    logic [L*CW-1:0] v = '0;
    for (int i = 0; i < L; i++) v[i*CW +: CW] = CW'(mq[i].size());
    return v;
  endfunction

  function automatic logic model_ready();
    logic r = 1'b1;
    for (int i = 0; i < L; i++) if (mq[i].size() >= D) r = 1'b0;
    return r;
  endfunction

  function automatic logic [L-1:0] model_empty();
    logic [L-1:0] e = '0;
    for (int i = 0; i < L; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  // Drive one cycle of stimulus at the falling edge and advance the model to the post-edge state.
  task automatic step(input logic wv, input logic [L*DW-1:0] wd, input logic [L-1:0] en, input logic fl);
    logic acc;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    fifo_en  = en;
    flush    = fl;
    acc = model_ready();
    if (fl) begin
      for (int i = 0; i < L; i++) mq[i].delete();
      m_uf = 1'b0;
    end else begin
      for (int i = 0; i < L; i++) begin
        if (en[i]) begin
          if (mq[i].size() > 0) sb[i].push_back(mq[i].pop_front());
          else m_uf = 1'b1;
        end
      end
      if (wv && acc)
        for (int i = 0; i < L; i++) mq[i].push_back(wd[i*DW +: DW]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    wr_valid = 1'b0;
    fifo_en  = '0;
    flush    = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_rd_valid",   64'(rd_valid),   64'(0));
    chk("rst_rd_data",    64'(rd_data),    64'(0));
    chk("rst_lane_count", 64'(lane_count), 64'(0));
    chk("rst_lane_empty", 64'(lane_empty), 64'({L{1'b1}}));
    chk("rst_wr_ready",   64'(wr_ready),   64'(1));
    chk("rst_underflow",  64'(underflow),  64'(0));
    for (int i = 0; i < L; i++) begin
      mq[i].delete();
      sb[i].delete();
    end
    m_uf = 1'b0;
    #1 reset = 1'b0;
  endtask

  // Monitor: runs just after every rising edge, independent of the stimulus process.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_on && !reset) begin
        for (int i = 0; i < L; i++) begin
          chk($sformatf("lane%0d_valid", i), 64'(rd_valid[i]), 64'(sb[i].size() != 0));
          if (sb[i].size() != 0) begin
            logic [DW-1:0] e;
            e = sb[i].pop_front();
            if (rd_valid[i]) chk($sformatf("lane%0d_data", i), 64'(rd_data[i*DW +: DW]), 64'(e));
          end else begin
            chk($sformatf("lane%0d_bubble", i), 64'(rd_data[i*DW +: DW]), 64'(0));
          end
        end
        chk("lane_count", 64'(lane_count), 64'(model_counts()));
        chk("lane_empty", 64'(lane_empty), 64'(model_empty()));
        chk("wr_ready",   64'(wr_ready),   64'(model_ready()));
        chk("underflow",  64'(underflow),  64'(m_uf));
      end
    end
  end

  initial begin
    logic [L*DW-1:0] rows [4];
    rows[0] = 32'h01020304;
    rows[1] = 32'h05060708;
    rows[2] = 32'h090A0B0C;
    rows[3] = 32'h0D0E0F10;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_on = 1'b1;

    // Skew: staggered enables after four rows.
    for (int r = 0; r < 4; r++) step(1'b1, rows[r], '0, 1'b0);
    step(1'b0, '0, 4'b0001, 1'b0);
    step(1'b0, '0, 4'b0011, 1'b0);
    step(1'b0, '0, 4'b0111, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 4'b1111, 1'b0);
    idle(2);

    // Full: fifth row refused, one pop re-enables writes only a cycle later.
    step(1'b0, '0, '0, 1'b1);
    for (int r = 0; r < 5; r++) step(1'b1, 32'($urandom), '0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 4'b1111, 1'b0);
    idle(1);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 4'b1111, 1'b0);

    // Underflow stays sticky through later valid pops until flush.
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 4'b0001, 1'b0);
    step(1'b1, 32'hA1B2C3D4, '0, 1'b0);
    step(1'b0, '0, 4'b1111, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b1);
    idle(1);

    // Concurrent push and pop with two rows resident, then on an empty bank.
    step(1'b1, 32'h11223344, '0, 1'b0);
    step(1'b1, 32'h55667788, '0, 1'b0);
    step(1'b1, 32'h99AABBCC, 4'b1111, 1'b0);
    idle(1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 32'hCAFEF00D, 4'b1111, 1'b0);
    idle(1);

    // Flush wins over a same-cycle push.
    step(1'b1, 32'h12345678, '0, 1'b0);
    step(1'b1, 32'h87654321, '0, 1'b1);
    idle(1);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 99) < 60), 32'($urandom), 4'($urandom),
           1'($urandom_range(0, 99) < 3));
    idle(2);

    // Reset in the middle of a stream.
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 32'h0BADF00D, '0, 1'b0);
    step(1'b1, 32'hFEEDFACE, 4'b0001, 1'b0);
    reset_pulse();
    idle(2);
    step(1'b1, 32'h13572468, '0, 1'b0);
    step(1'b0, '0, 4'b1111, 1'b0);
    idle(2);

    mon_on = 1'b0;
    for (int i = 0; i < L; i++) chk($sformatf("sb_drained%0d", i), 64'(sb[i].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
